warp_registers: RTL and testbench

Parametrised register file for a whole block of threads: one register bank per thread lane behind shared decoded addresses, with a per-lane active mask and a pending-load scoreboard, so load data can return out of order through a separate write-back port while the core keeps issuing. It sits in each core between the decoder, the ALUs and the LSUs. It replaces the per-thread register instances.

---
 rtl/warp_registers_if.sv | 43 ++++
 rtl/warp_registers.sv | 149 ++++++++++++++
 tb/tb_warp_registers.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/warp_registers_if.sv
// Decoder, ALU, LSU and operand bundle for warp_registers.
// Master is the core side; slave is the register file.
interface warp_registers_if #(
  parameter int THREADS   = 4,
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16
);
  localparam int AB = $clog2(NUM_REGS);

  logic                         enable;
  logic [THREADS-1:0]           thread_mask;
  logic [DATA_BITS-1:0]         block_id;
  logic [2:0]                   core_state;
  logic                         dec_reg_write_en;
  logic [1:0]                   dec_reg_input_mux;
  logic [AB-1:0]                dec_rs_address;
  logic [AB-1:0]                dec_rt_address;
  logic [AB-1:0]                dec_rd_address;
  logic [DATA_BITS-1:0]         dec_imm;
  logic [THREADS*DATA_BITS-1:0] alu_out;
  logic [THREADS-1:0]           wb_valid;
  logic [THREADS*AB-1:0]        wb_rd;
  logic [THREADS*DATA_BITS-1:0] wb_data;
  logic [THREADS*DATA_BITS-1:0] rs;
  logic [THREADS*DATA_BITS-1:0] rt;
  logic                         stall;

  modport master (
    output enable, thread_mask, block_id, core_state,
    output dec_reg_write_en, dec_reg_input_mux,
    output dec_rs_address, dec_rt_address, dec_rd_address,
    output dec_imm, alu_out, wb_valid, wb_rd, wb_data,
    input  rs, rt, stall
  );

  modport slave (
    input  enable, thread_mask, block_id, core_state,
    input  dec_reg_write_en, dec_reg_input_mux,
    input  dec_rs_address, dec_rt_address, dec_rd_address,
    input  dec_imm, alu_out, wb_valid, wb_rd, wb_data,
    output rs, rt, stall
  );
endinterface

// File: rtl/warp_registers.sv
// Per-lane register banks with shared addressing, active mask,
// out-of-order load write-back and a pending-load scoreboard.
module warp_registers #(
  parameter int THREADS   = 4,
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16
) (
  input logic              clk,
  input logic              reset,
  warp_registers_if.slave  bus
);
  localparam int AB = $clog2(NUM_REGS);
  localparam int DB = DATA_BITS;

  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] UPDATE  = 3'b110;

  localparam logic [1:0] MUX_ARITH = 2'b00;
  localparam logic [1:0] MUX_CONST = 2'b01;
  localparam logic [1:0] MUX_MEM   = 2'b10;
  localparam logic [1:0] MUX_RSVD  = 2'b11;

  localparam logic [AB-1:0] BID  = AB'(NUM_REGS - 3);
  localparam logic [AB-1:0] BDIM = AB'(NUM_REGS - 2);
  localparam logic [AB-1:0] TID  = AB'(NUM_REGS - 1);

  typedef logic [DB-1:0] word_t;

  // Special entries of gp_q/pend_q are never written and stay 0.
  word_t                gp_q   [THREADS][NUM_REGS];
  word_t                gp_d   [THREADS][NUM_REGS];
  logic [NUM_REGS-1:0]  pend_q [THREADS];
  logic [NUM_REGS-1:0]  pend_d [THREADS];
  word_t                bid_q, bid_d;
  logic [THREADS*DB-1:0] rs_q, rs_d;
  logic [THREADS*DB-1:0] rt_q, rt_d;

  logic [THREADS-1:0]    wb_valid;
  logic [THREADS*AB-1:0] wb_rd;
  logic [THREADS*DB-1:0] wb_data;
  logic                  is_req;
  logic                  is_upd;
  logic                  hit;

  assign wb_valid = bus.wb_valid;
  assign wb_rd    = bus.wb_rd;
  assign wb_data  = bus.wb_data;

  assign is_req = bus.enable && (bus.core_state == REQUEST);
  assign is_upd = bus.enable && (bus.core_state == UPDATE) &&
                  bus.dec_reg_write_en &&
                  (bus.dec_rd_address < BID);

  function automatic word_t rd_val(input int t,
                                   input logic [AB-1:0] a);
    word_t v;
    logic [AB-1:0] wa;
    wa = wb_rd[t*AB +: AB];
    if (a == BID)
      v = bid_q;
    else if (a == BDIM)
      v = DB'(THREADS);
    else if (a == TID)
      v = DB'(t);
    else if (wb_valid[t] && wa == a)
      v = wb_data[t*DB +: DB];
    else
      v = gp_q[t][a];
    return v;
  endfunction

  // Operand read on REQUEST, with same-cycle load forwarding.
  always_comb begin
    rs_d = rs_q;
    rt_d = rt_q;
    if (is_req) begin
      for (int t = 0; t < THREADS; t++) begin
        rs_d[t*DB +: DB] = rd_val(t, bus.dec_rs_address);
        rt_d[t*DB +: DB] = rd_val(t, bus.dec_rt_address);
      end
    end
  end

  // Write-back first, then UPDATE so it overrides on collision.
  always_comb begin
    logic [AB-1:0] wa;
    logic [AB-1:0] rd;
    gp_d   = gp_q;
    pend_d = pend_q;
    bid_d  = bus.enable ? bus.block_id : bid_q;
    rd     = bus.dec_rd_address;
    for (int t = 0; t < THREADS; t++) begin
      wa = wb_rd[t*AB +: AB];
      if (wb_valid[t] && wa < BID) begin
        gp_d[t][wa]   = wb_data[t*DB +: DB];
        pend_d[t][wa] = 1'b0;
      end
      if (is_upd && bus.thread_mask[t]) begin
        unique case (bus.dec_reg_input_mux)
          MUX_ARITH: begin
            gp_d[t][rd]   = bus.alu_out[t*DB +: DB];
            pend_d[t][rd] = 1'b0;
          end
          MUX_CONST: begin
            gp_d[t][rd]   = bus.dec_imm;
            pend_d[t][rd] = 1'b0;
          end
          MUX_MEM:  pend_d[t][rd] = 1'b1;
          MUX_RSVD: gp_d[t][rd]   = '0;
        endcase
      end
    end
  end

  // Hazard on any active lane's source or destination.
  always_comb begin
    hit = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      if (bus.thread_mask[t]) begin
        hit = hit |
              pend_q[t][bus.dec_rs_address] |
              pend_q[t][bus.dec_rt_address] |
              (bus.dec_reg_write_en &
               pend_q[t][bus.dec_rd_address]);
      end
    end
  end

  assign bus.stall = is_req && hit;
  assign bus.rs    = rs_q;
  assign bus.rt    = rt_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gp_q   <= '{default: '0};
      pend_q <= '{default: '0};
      bid_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
    end else begin
      gp_q   <= gp_d;
      pend_q <= pend_d;
      bid_q  <= bid_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
    end
  end
endmodule

// File: tb/tb_warp_registers.sv
// Directed vector table plus randomized run against a
// lane-level register file model.
module tb_warp_registers;
  localparam bit [2:0] R = 3'b011;
  localparam bit [2:0] U = 3'b110;
  localparam bit [2:0] I = 3'b000;

  typedef struct {
    string     name;
    bit        rst, en;
    bit [2:0]  cs;
    bit [3:0]  mask;
    bit        we;
    bit [1:0]  mux;
    bit [3:0]  ra, rb, rd;
    bit [7:0]  imm, bid;
    bit [3:0]  wbv;
    bit [15:0] wbrd;
    bit [31:0] wbd, alu;
    bit        ck;
    bit [31:0] ers, ert;
    bit        est;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t tv[$];

  bit [7:0] m_reg  [4][16];
  bit       m_pend [4][16];
  bit [7:0] m_rs [4];
  bit [7:0] m_rt [4];

  warp_registers_if #(.THREADS(4), .DATA_BITS(8), .NUM_REGS(16)) bus();

  warp_registers #(.THREADS(4), .DATA_BITS(8), .NUM_REGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(string n, bit rst, bit en, bit [2:0] cs,
      bit [3:0] mask, bit we, bit [1:0] mux, bit [3:0] ra, bit [3:0] rb,
      bit [3:0] rd, bit [7:0] imm, bit [7:0] bid, bit [3:0] wbv,
      bit [15:0] wbrd, bit [31:0] wbd, bit [31:0] alu, bit ck,
      bit [31:0] ers, bit [31:0] ert, bit est);
    vec_t v;
    v.name = n; v.rst = rst; v.en = en; v.cs = cs; v.mask = mask;
    v.we = we; v.mux = mux; v.ra = ra; v.rb = rb; v.rd = rd;
    v.imm = imm; v.bid = bid; v.wbv = wbv; v.wbrd = wbrd;
    v.wbd = wbd; v.alu = alu; v.ck = ck; v.ers = ers; v.ert = ert;
    v.est = est;
    tv.push_back(v);
  endfunction

  function automatic bit [31:0] pack(bit [7:0] a [4]);
    return {a[3], a[2], a[1], a[0]};
  endfunction

  // Model: lane t sees R13=block id, R14=4, R15=t; GP below 13.
  function automatic bit m_stall(vec_t v);
    bit h = 0;
    for (int t = 0; t < 4; t++)
      if (v.mask[t])
        h |= m_pend[t][v.ra] | m_pend[t][v.rb] |
             (v.we & m_pend[t][v.rd]);
    return v.en && v.cs == R && h;
  endfunction

  function automatic void m_step(vec_t v);
    bit [7:0] nreg  [4][16];
    bit       npend [4][16];
    int       a;
    if (v.rst) begin
      for (int t = 0; t < 4; t++) begin
        for (int r = 0; r < 16; r++) begin
          m_reg[t][r]  = (r == 15) ? 8'(t) : (r == 14) ? 8'd4 : 8'd0;
          m_pend[t][r] = 0;
        end
        m_rs[t] = 0;
        m_rt[t] = 0;
      end
      return;
    end
    nreg  = m_reg;
    npend = m_pend;
    for (int t = 0; t < 4; t++) begin
      a = int'(v.wbrd[t*4 +: 4]);
      if (v.en && v.cs == R) begin
        m_rs[t] = (v.wbv[t] && a < 13 && a == int'(v.ra))
                  ? v.wbd[t*8 +: 8] : m_reg[t][v.ra];
        m_rt[t] = (v.wbv[t] && a < 13 && a == int'(v.rb))
                  ? v.wbd[t*8 +: 8] : m_reg[t][v.rb];
      end
      if (v.wbv[t] && a < 13) begin
        nreg[t][a]  = v.wbd[t*8 +: 8];
        npend[t][a] = 0;
      end
      if (v.en && v.cs == U && v.we && v.rd < 13 && v.mask[t]) begin
        case (v.mux)
          2'd0: begin nreg[t][v.rd] = v.alu[t*8 +: 8]; npend[t][v.rd] = 0; end
          2'd1: begin nreg[t][v.rd] = v.imm; npend[t][v.rd] = 0; end
          2'd2: npend[t][v.rd] = 1;
          default: nreg[t][v.rd] = 0;
        endcase
      end
      if (v.en) nreg[t][13] = v.bid;
    end
    m_reg  = nreg;
    m_pend = npend;
  endfunction

  task automatic check(string n, bit [31:0] act, bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic run(vec_t v, bit use_model);
    reset                 = v.rst;
    bus.enable            = v.en;
    bus.core_state        = v.cs;
    bus.thread_mask       = v.mask;
    bus.dec_reg_write_en  = v.we;
    bus.dec_reg_input_mux = v.mux;
    bus.dec_rs_address    = v.ra;
    bus.dec_rt_address    = v.rb;
    bus.dec_rd_address    = v.rd;
    bus.dec_imm           = v.imm;
    bus.block_id          = v.bid;
    bus.wb_valid          = v.wbv;
    bus.wb_rd             = v.wbrd;
    bus.wb_data           = v.wbd;
    bus.alu_out           = v.alu;
    #1;
    if (use_model) begin
      check({v.name, "_stall"}, 32'(bus.stall), 32'(m_stall(v)));
      m_step(v);
    end else begin
      check({v.name, "_stall"}, 32'(bus.stall), 32'(v.est));
    end
    @(posedge clk);
    #1;
    if (use_model) begin
      check({v.name, "_rs"}, bus.rs, pack(m_rs));
      check({v.name, "_rt"}, bus.rt, pack(m_rt));
    end else if (v.ck) begin
      check({v.name, "_rs"}, bus.rs, v.ers);
      check({v.name, "_rt"}, bus.rt, v.ert);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.enable = 0; bus.core_state = I; bus.thread_mask = 0;
    bus.dec_reg_write_en = 0; bus.dec_reg_input_mux = 0;
    bus.dec_rs_address = 0; bus.dec_rt_address = 0;
    bus.dec_rd_address = 0; bus.dec_imm = 0; bus.block_id = 0;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.alu_out = 0;
    @(negedge clk);

    add("reset",  1,0,I,4'hF,0,0, 0, 0, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h0,32'h0,0);
    add("bid_bdim",0,1,R,4'hF,0,0,13,14, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h0,32'h04040404,0);
    add("tid",    0,1,R,4'hF,0,0,15,13, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h03020100,32'h09090909,0);
    add("wr_r15", 0,1,U,4'hF,1,1, 0, 0,15,8'hFF,8'h09,4'h0,16'h0000,32'h0,32'h0, 0,32'h0,32'h0,0);
    add("r15_ro", 0,1,R,4'hF,0,0,15,15, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h03020100,32'h03020100,0);
    add("cst_upd",0,1,U,4'h5,1,1, 0, 0, 2,8'h5A,8'h09,4'h0,16'h0000,32'h0,32'h0, 0,32'h0,32'h0,0);
    add("mask",   0,1,R,4'hF,0,0, 2,13, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h005A005A,32'h09090909,0);
    add("mem_upd",0,1,U,4'hF,1,2, 0, 0, 3,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 0,32'h0,32'h0,0);
    add("mem_stl",0,1,R,4'hF,0,0, 3, 0, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h0,32'h0,1);
    add("wb_02",  0,1,R,4'hF,0,0, 3, 0, 0,8'h00,8'h09,4'h5,16'h0303,32'h00330011,32'h0, 1,32'h00330011,32'h0,1);
    add("stl_hld",0,1,R,4'hF,0,0, 3, 0, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h00330011,32'h0,1);
    add("wb_13",  0,1,R,4'hF,0,0, 3, 0, 0,8'h00,8'h09,4'hA,16'h3030,32'h44002200,32'h0, 1,32'h44332211,32'h0,1);
    add("stl_clr",0,1,R,4'hF,0,0, 3, 0, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h44332211,32'h0,0);
    add("fwd",    0,1,R,4'hF,0,0, 4, 0, 0,8'h00,8'h09,4'h2,16'h0040,32'h00007E00,32'h0, 1,32'h00007E00,32'h0,0);
    add("en0",    0,0,R,4'hF,0,0, 0, 0, 0,8'h00,8'h77,4'h8,16'h5000,32'hC3000000,32'h0, 1,32'h00007E00,32'h0,0);
    add("en0_wb", 0,1,R,4'hF,0,0, 5,13, 0,8'h00,8'h21,4'h0,16'h0000,32'h0,32'h0, 1,32'hC3000000,32'h09090909,0);
    add("bid_cap",0,1,R,4'hF,0,0,13,13, 0,8'h00,8'h21,4'h0,16'h0000,32'h0,32'h0, 1,32'h21212121,32'h21212121,0);
    add("mem6",   0,1,U,4'h1,1,2, 0, 0, 6,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 0,32'h0,32'h0,0);
    add("stl6",   0,1,R,4'hF,0,0, 6, 0, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h0,32'h0,1);
    add("rst_wb", 1,0,R,4'hF,0,0, 6, 0, 0,8'h00,8'h09,4'h1,16'h0006,32'h000000AA,32'h0, 1,32'h0,32'h0,0);
    add("rst_clr",0,1,R,4'hF,0,0, 6,14, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h0,32'h04040404,0);
    add("late_wb",0,1,I,4'hF,0,0, 0, 0, 0,8'h00,8'h09,4'h1,16'h0006,32'h0000005C,32'h0, 0,32'h0,32'h0,0);
    add("late_rd",0,1,R,4'hF,0,0, 6, 0, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h0000005C,32'h0,0);
    add("alu_wb", 0,1,U,4'hF,1,0, 0, 0, 7,8'h00,8'h09,4'h4,16'h0700,32'h00EE0000,32'hA1B2C3D4, 0,32'h0,32'h0,0);
    add("alu_rd", 0,1,R,4'hF,0,0, 7, 0, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'hA1B2C3D4,32'h0,0);
    add("mem_wb", 0,1,U,4'hF,1,2, 0, 0, 8,8'h00,8'h09,4'h2,16'h0080,32'h00009900,32'h0, 0,32'h0,32'h0,0);
    add("mem_wbr",0,1,R,4'hF,0,0, 8, 0, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h00009900,32'h0,1);
    add("rsvd",   0,1,U,4'h1,1,3, 0, 0, 7,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 0,32'h0,32'h0,0);
    add("rsvd_rd",0,1,R,4'hF,0,0, 7, 8, 0,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'hA1B2C300,32'h00009900,1);
    add("rd_haz", 0,1,R,4'hF,1,0, 0, 0, 8,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h0,32'h0,1);
    add("rd_nohz",0,1,R,4'hF,0,0, 0, 0, 8,8'h00,8'h09,4'h0,16'h0000,32'h0,32'h0, 1,32'h0,32'h0,0);

    foreach (tv[i]) run(tv[i], 1'b0);

    for (int n = 0; n < 600; n++) begin
      bit [2:0] states [4];
      states = '{R, U, I, 3'b001};
      v.name = "rand";
      v.rst  = (n == 0) || ($urandom_range(0, 49) == 0);
      v.en   = $urandom_range(0, 9) != 0;
      v.cs   = states[$urandom_range(0, 3)];
      v.mask = 4'($urandom);
      v.we   = 1'($urandom);
      v.mux  = 2'($urandom);
      v.ra   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      v.rb   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      v.rd   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      v.imm  = 8'($urandom);
      v.bid  = 8'($urandom);
      v.wbv  = 4'($urandom) & 4'($urandom);
      for (int t = 0; t < 4; t++)
        v.wbrd[t*4 +: 4] = ($urandom_range(0, 5) == 0) ?
                           4'($urandom) : 4'($urandom_range(0, 5));
      v.wbd = $urandom;
      v.alu = $urandom;
      v.ck = 1; v.ers = 0; v.ert = 0; v.est = 0;
      run(v, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
